// File: rtl/pulse_meter.sv
// pulse_meter: measures period and high-width of a periodic single-bit pulse train.
//
// Each complete cycle (rise to rise) is reported in clock cycles over a
// valid/ready interface. The first partial period after leaving IDLE is
// discarded. Sticky overrun flags a result overwritten before acceptance;
// timeout flags a pulse train that has stopped.
//
// Optional feature: define PULSE_METER_SYNC_EN to pass pulse_in through a
// 2-flop synchroniser (for asynchronous sources). Adds 2 cycles of latency,
// measured values are unchanged.
//
// Parameters:
//   COUNT_WIDTH  width of the internal counter and of period_out/width_out
//   TIMEOUT      cycles without an edge before timeout (< 2^COUNT_WIDTH-1)
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous reset, active-high
//   en          measurement enable
//   pulse_in    pulse train
//   m_ready     downstream accepts the result
//   m_valid     result available
//   period_out  cycles from one rising edge to the next
//   width_out   cycles pulse_in was high in that period
//   overrun     sticky: an unaccepted result was overwritten
//   timeout     no edge seen for TIMEOUT cycles
//   locked      at least one full period measured since the last IDLE entry

module pulse_meter #(
  parameter int unsigned COUNT_WIDTH = 32,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   pulse_in,
  input  logic                   m_ready,
  output logic                   m_valid,
  output logic [COUNT_WIDTH-1:0] period_out,
  output logic [COUNT_WIDTH-1:0] width_out,
  output logic                   overrun,
  output logic                   timeout,
  output logic                   locked
);

  typedef enum logic [2:0] {
    StIdle,
    StFirstHigh,
    StFirstLow,
    StHigh,
    StLow
  } state_e;

  localparam logic [COUNT_WIDTH-1:0] TimeoutCnt = COUNT_WIDTH'(TIMEOUT);
  localparam logic [COUNT_WIDTH-1:0] CntOne     = COUNT_WIDTH'(1);

  state_e                 state;
  logic [COUNT_WIDTH-1:0] cnt;
  logic [COUNT_WIDTH-1:0] width_cap;
  logic                   prev;
  logic                   p;
  logic                   rise;
  logic                   fall;
  logic                   publish;
  logic                   expire;

`ifdef PULSE_METER_SYNC_EN
  logic [1:0] sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[0], pulse_in};
    end
  end

  assign p = sync[1];
`else
  assign p = pulse_in;
`endif

  assign rise    = p & ~prev;
  assign fall    = ~p & prev;
  // A rise closes a full period only once the first partial period is gone.
  assign publish = en && rise && ((state == StFirstLow) || (state == StLow));
  // cnt restarts only on a rise, so a stuck level in either phase expires.
  assign expire  = en && (state != StIdle) && !rise && !fall && (cnt == TimeoutCnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      cnt        <= '0;
      width_cap  <= '0;
      prev       <= 1'b0;
      m_valid    <= 1'b0;
      period_out <= '0;
      width_out  <= '0;
      overrun    <= 1'b0;
      timeout    <= 1'b0;
      locked     <= 1'b0;
    end else begin
      prev <= p;

      if (!en) begin
        state  <= StIdle;
        cnt    <= '0;
        locked <= 1'b0;
      end else begin
        if (rise) begin
          cnt <= CntOne;
        end else if (cnt != '1) begin
          cnt <= cnt + CntOne;
        end

        if (expire) begin
          state  <= StIdle;
          locked <= 1'b0;
        end else begin
          unique case (state)
            StIdle: begin
              if (rise) state <= StFirstHigh;
            end
            StFirstHigh: begin
              if (fall) begin
                state     <= StFirstLow;
                width_cap <= cnt;
              end
            end
            StFirstLow: begin
              if (rise) begin
                state  <= StHigh;
                locked <= 1'b1;
              end
            end
            StHigh: begin
              if (fall) begin
                state     <= StLow;
                width_cap <= cnt;
              end
            end
            StLow: begin
              if (rise) begin
                state  <= StHigh;
                locked <= 1'b1;
              end
            end
            default: state <= StIdle;
          endcase
        end
      end

      if (expire) begin
        timeout <= 1'b1;
      end else if (rise) begin
        timeout <= 1'b0;
      end

      // A publish wins over a same-cycle transfer: valid stays high with new data.
      if (publish) begin
        period_out <= cnt;
        width_out  <= width_cap;
        m_valid    <= 1'b1;
        if (m_valid && !m_ready) overrun <= 1'b1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule
